shared_vc_buffer_ctrl: RTL
==========================

# shared_vc_buffer_ctrl

Shared input-buffer controller for a dynamically allocated VC router port. Incoming flits of any VC are written into one shared memory bank at slots handed out by `free_buffer_tracker`. Per-VC FIFO order is kept as linked lists in a next-pointer RAM. Read-out flits return their slot to the tracker. The block sits directly downstream of `free_buffer_tracker`: it consumes `next_available_slot` and drives the tracker's `read_enable`, `write_enable` and `new_freed_slot`.

## Interface
- `num_vcs`, default 4: number of VCs sharing the bank.
- `memory_bank_depth`, default 32: slots in the bank; must match the tracker.
- `memory_bank_width`, default 64: flit width in bits.
- Derived widths: `vc_idx_width=clogb(num_vcs)`, `memory_addr_width=clogb(memory_bank_depth)`, `count_width=clogb(memory_bank_depth+1)`.

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `flit_valid`  in  1  write request.
- `flit_vc`  in  vc_idx_width  destination VC of the write.
- `flit_data`  in  memory_bank_width  flit payload.
- `read_en`  in  1  read request.
- `read_vc`  in  vc_idx_width  VC to pop.
- `read_data`  out  memory_bank_width  popped flit, registered.
- `read_valid`  out  1  `read_data` is valid.
- `vc_empty`  out  num_vcs  per-VC empty flags; bit i is VC i.
- `vc_count`  out  num_vcs*count_width  per-VC occupancy; VC 0 is in the MSB field.
- `next_available_slot`  in  memory_addr_width  free slot offered by the tracker.
- `pool_empty`  in  1  tracker has no free slot (tracker `memory_bank_empty`).
- `alloc_slot_en`  out  1  consume the offered slot (tracker `read_enable`).
- `free_slot_en`  out  1  return a slot (tracker `write_enable`).
- `freed_slot`  out  memory_addr_width  slot being returned (tracker `new_freed_slot`).
- `error_overflow`  out  1  one-cycle pulse: write dropped.
- `error_underflow`  out  1  one-cycle pulse: read of an empty VC ignored.

## Operation
- Storage:
  - Data RAM: depth × width.
  - Next-pointer RAM: depth × addr_width.
  - Per-VC registers: `head`, `tail`, `count`.
  - RAMs are not reset; all registers are.
- Write is accepted when `flit_valid & ~pool_empty`. The accepted slot is `s = next_available_slot`. On the next edge:
  - `data[s] <= flit_data`.
  - If `count[flit_vc]==0`: `head <= s`. Otherwise: `next[tail[flit_vc]] <= s`.
  - `tail <= s`; `count` increments.
- Write with `pool_empty=1`: dropped, no state change, `error_overflow` pulses.
- Read is accepted when `read_en & count[read_vc]!=0`. The popped slot is `h = head[read_vc]`. On the next edge:
  - `read_data <= data[h]`, `read_valid <= 1`.
  - `head <= next[h]`; `count` decrements.
- Read of an empty VC: ignored, `read_valid <= 0`, `error_underflow` pulses.
- Tracker handshake, all combinational from the current cycle's inputs:
  - `alloc_slot_en` = write accepted.
  - `free_slot_en` = read accepted.
  - `freed_slot` = `h`; it is 0 when no read is accepted.
- Simultaneous write and read, different VCs: both proceed independently.
- Simultaneous write and read, same VC:
  - count ≥ 2: both proceed normally; count is unchanged.
  - count == 1: bypass. `head <= s` (not `next[h]`), `tail <= s`, count stays 1.
  - count == 0: write accepted, read is underflow; final count is 1.
- The freed slot never equals the allocated slot in the same cycle, because an allocated slot is always free. No hazard handling is needed.
- `vc_empty[i] = (count[i]==0)`. `vc_count` is the direct register view.

## Timing
- Write latency: the flit is readable the cycle after acceptance. Read data arrives 1 cycle after the accepted `read_en`.
- Reset values:
  - `head`, `tail`, `count` = 0; `vc_empty` = all 1s; `vc_count` = 0.
  - `read_data` = 0, `read_valid` = 0, `error_overflow` = 0, `error_underflow` = 0.
  - `alloc_slot_en` and `free_slot_en` are 0 while reset is high.
- Reset asserted mid-operation clears all registers immediately. Stored flits are lost and the tracker is reset alongside.
- `read_valid` and both error outputs are single-cycle pulses. Back-to-back reads give one flit per cycle.
- Sustained throughput: one write plus one read every cycle.

## Test plan
- Reset, then write 3 flits to VC 2 (tracker offers slots 0, 1, 2), then 3 reads of VC 2 → `read_data` returns the flits in order, one cycle after each `read_en`. `freed_slot` = 0, 1, 2. `vc_empty[2]` returns to 1.
- Interleave writes to VC 0 and VC 1, e.g. alternating A0, B0, A1, B1. Drain VC 1 first → B0, B1, then A0, A1. Linked lists stay independent.
- VC 3 holds 1 flit; write and read VC 3 in the same cycle → the old flit is output, count stays 1, and the next read returns the new flit.
- Fill the bank with 32 writes until `pool_empty=1`, then one more write → `error_overflow` pulses once, `alloc_slot_en`=0, all counts unchanged.
- `read_en` on an empty VC → `error_underflow` pulses, `read_valid`=0, `free_slot_en`=0.
- Assert reset with 5 flits stored → the next cycle shows all counts 0, `vc_empty` all 1s and `read_valid`=0.

Source files
------------

// File: rtl/shared_vc_buffer_ctrl.sv
// Shared-bank input buffer: per-VC FIFOs kept as linked lists over slots granted by the free-slot tracker.
// Write visible next cycle, read data 1 cycle after accepted read_en; no backpressure, drops flag error_overflow/underflow.
module shared_vc_buffer_ctrl #(
    parameter  int num_vcs           = 4,
    parameter  int memory_bank_depth = 32,
    parameter  int memory_bank_width = 64,
    localparam int vc_idx_width      = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int memory_addr_width = $clog2(memory_bank_depth),
    localparam int count_width       = $clog2(memory_bank_depth + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flit_valid,
    input  logic [vc_idx_width-1:0]            flit_vc,
    input  logic [memory_bank_width-1:0]       flit_data,
    input  logic                               read_en,
    input  logic [vc_idx_width-1:0]            read_vc,
    output logic [memory_bank_width-1:0]       read_data,
    output logic                               read_valid,
    output logic [num_vcs-1:0]                 vc_empty,
    output logic [num_vcs*count_width-1:0]     vc_count,
    input  logic [memory_addr_width-1:0]       next_available_slot,
    input  logic                               pool_empty,
    output logic                               alloc_slot_en,
    output logic                               free_slot_en,
    output logic [memory_addr_width-1:0]       freed_slot,
    output logic                               error_overflow,
    output logic                               error_underflow
);

    logic [memory_bank_width-1:0] r_data [memory_bank_depth];
    logic [memory_addr_width-1:0] r_next [memory_bank_depth];

    logic [memory_addr_width-1:0] w_head  [num_vcs];
    logic [memory_addr_width-1:0] w_tail  [num_vcs];
    logic [count_width-1:0]       w_count [num_vcs];

    logic                         w_wr_acc;
    logic                         w_rd_acc;
    logic [memory_addr_width-1:0] w_slot;
    logic [memory_addr_width-1:0] w_head_rd;
    logic [memory_addr_width-1:0] w_next_head;

    logic [memory_bank_width-1:0] r_read_data;
    logic                         r_read_valid;
    logic                         r_err_ovf;
    logic                         r_err_unf;

    assign w_slot      = next_available_slot;
    assign w_wr_acc    = ~reset & flit_valid & ~pool_empty;
    assign w_rd_acc    = ~reset & read_en & (w_count[read_vc] != '0);
    assign w_head_rd   = w_head[read_vc];
    assign w_next_head = r_next[w_head_rd];

    assign alloc_slot_en = w_wr_acc;
    assign free_slot_en  = w_rd_acc;
    assign freed_slot    = w_rd_acc ? w_head_rd : '0;

    for (genvar g = 0; g < num_vcs; g++) begin : gen_vc
        logic [memory_addr_width-1:0] r_head;
        logic [memory_addr_width-1:0] r_tail;
        logic [count_width-1:0]       r_count;
        logic                         w_wr;
        logic                         w_rd;

        assign w_wr = w_wr_acc & (flit_vc == vc_idx_width'(g));
        assign w_rd = w_rd_acc & (read_vc == vc_idx_width'(g));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr) begin
                    r_tail <= w_slot;
                end
                // Single-entry list popped and pushed together: the new slot becomes the head directly.
                if (w_wr && ((r_count == '0) || (w_rd && (r_count == count_width'(1))))) begin
                    r_head <= w_slot;
                end else if (w_rd) begin
                    r_head <= w_next_head;
                end
                if (w_wr && !w_rd) begin
                    r_count <= r_count + count_width'(1);
                end else if (w_rd && !w_wr) begin
                    r_count <= r_count - count_width'(1);
                end
            end
        end

        assign w_head[g]  = r_head;
        assign w_tail[g]  = r_tail;
        assign w_count[g] = r_count;
        assign vc_empty[g] = (r_count == '0);
        assign vc_count[(num_vcs-1-g)*count_width +: count_width] = r_count;
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_data[w_slot] <= flit_data;
            if (w_count[flit_vc] != '0) begin
                r_next[w_tail[flit_vc]] <= w_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
        end else begin
            r_read_valid <= w_rd_acc;
            r_err_ovf    <= flit_valid & pool_empty;
            r_err_unf    <= read_en & (w_count[read_vc] == '0);
            if (w_rd_acc) begin
                r_read_data <= r_data[w_head_rd];
            end
        end
    end

    assign read_data       = r_read_data;
    assign read_valid      = r_read_valid;
    assign error_overflow  = r_err_ovf;
    assign error_underflow = r_err_unf;

endmodule
